// File: rtl/uart_pkg.sv
// Shared state encoding and timing constants for the UART transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_core_if.sv
// Bus-side connection between the TX FIFO/controller and the UART transmitter core.
interface uart_tx_core_if #(
  parameter int DVSR_W = 11
);

  logic [DVSR_W-1:0] dvsr;
  logic              tx_start;
  logic [7:0]        din;
  logic              tick;
  logic              tx_done_tick;
  logic              tx;

  modport master (
    output dvsr, tx_start, din,
    input  tick, tx_done_tick, tx
  );

  modport slave (
    input  dvsr, tx_start, din,
    output tick, tx_done_tick, tx
  );

endinterface

// File: rtl/baud_gen.sv
// Free-running oversampling tick generator: one strobe every dvsr+1 clocks.
module baud_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] r_q, r_d;

  // Using >= lets a lowered divisor wrap immediately instead of running to overflow.
  always_comb begin
    tick = (r_q >= dvsr);
    r_d  = tick ? '0 : r_q + DVSR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK-tick stop period.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_core_if.slave bus
);

  // Stop periods longer than one bit need a wider tick counter.
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

  tx_state_t      state_q, state_d;
  logic [S_W-1:0] s_q, s_d;
  logic [2:0]     n_q, n_d;
  logic [7:0]     b_q, b_d;
  logic           tx_q, tx_d;
  logic           tick;
  logic           done;

  baud_gen #(
    .DVSR_W (DVSR_W)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .dvsr  (bus.dvsr),
    .tick  (tick)
  );

  assign bus.tick         = tick;
  assign bus.tx           = tx_q;
  assign bus.tx_done_tick = done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          s_d     = '0;
          b_d     = bus.din;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (tick) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == 3'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomised scoreboard bench: stimulus queues expected frames, a line monitor decodes tx.
module tb_uart_tx_core;

  localparam int DVSR_W      = 11;
  localparam int FRAME_TICKS = 16 * (1 + 8) + 16;

  logic clk;
  logic reset;

  uart_tx_core_if #(.DVSR_W(DVSR_W)) bus ();

  uart_tx_core #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR_W  (DVSR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sb[$];
  int passCount  = 0;
  int checkCount = 0;
  int expDone    = 0;
  int doneCount  = 0;
  int gapExp     = -1;

  // A UART frame as seen on the wire, oldest bit in position 0.
  function automatic logic [9:0] frameOf(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checkCount++;
    if (actual >= lo && actual <= hi) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int len, input bit doPush);
    bus.din      = data;
    bus.tx_start = 1'b1;
    if (doPush) begin
      sb.push_back(frameOf(data));
      expDone++;
    end
    repeat (len) @(negedge clk);
    bus.tx_start = 1'b0;
    bus.din      = 8'($urandom);
  endtask

  task automatic waitDone(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (bus.tx_done_tick) seen = 1'b1;
    end
    if (!seen) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkTickPeriod(input int d);
    int k;
    bus.dvsr = DVSR_W'(d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tick && k < d + 3);
    checkOutput($sformatf("tickFound_d%0d", d), int'(bus.tick), 1);
    for (int i = 1; i <= 3 * (d + 1); i++) begin
      @(negedge clk);
      checkOutput($sformatf("tickPhase%0d_d%0d", i, d), int'(bus.tick), int'((i % (d + 1)) == 0));
    end
  endtask

  task automatic monWait(input int n, inout int off, inout bit abort);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      off++;
      if (reset) begin
        abort = 1'b1;
        return;
      end
    end
  endtask

  initial begin : doneCounter
    forever begin
      @(negedge clk);
      if (!reset && bus.tx_done_tick) doneCount++;
    end
  end

  // Decodes each frame at mid-bit and checks the done pulse lands on the last stop tick.
  initial begin : monitor
    bit         txPrev;
    bit         haveDone;
    bit         abort;
    bit         found;
    int         gapCnt;
    int         d;
    int         bitCyc;
    int         off;
    int         lo;
    int         hi;
    logic [9:0] got;
    logic [9:0] expFrame;
    txPrev   = 1'b1;
    haveDone = 1'b0;
    gapCnt   = 0;
    forever begin
      @(negedge clk);
      gapCnt++;
      if (reset) begin
        txPrev   = 1'b1;
        haveDone = 1'b0;
      end else if (txPrev && !bus.tx) begin
        if (haveDone && gapExp >= 0) checkOutput("frameGap", gapCnt, gapExp);
        d      = int'(bus.dvsr);
        bitCyc = 16 * (d + 1);
        off    = 0;
        abort  = 1'b0;
        got    = '0;
        monWait(bitCyc / 2, off, abort);
        for (int i = 0; i < 10 && !abort; i++) begin
          got[i] = bus.tx;
          if (i < 9) monWait(bitCyc, off, abort);
        end
        if (!abort) begin
          lo    = (FRAME_TICKS - 1) * (d + 1) - 1;
          hi    = lo + d;
          found = 1'b0;
          while (!found && !abort && off < hi + 5) begin
            monWait(1, off, abort);
            if (!abort && bus.tx_done_tick) found = 1'b1;
          end
        end
        if (!abort) begin
          checkOutput("doneSeen", int'(found), 1);
          if (found) begin
            checkRange("doneOffset", off, lo, hi);
            checkOutput("txHighAtDone", int'(bus.tx), 1);
          end
          checkOutput("frameExpected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            expFrame = sb.pop_front();
            checkOutput("frame", int'(got), int'(expFrame));
          end
          haveDone = 1'b1;
          gapCnt   = 0;
        end else begin
          haveDone = 1'b0;
        end
        txPrev = 1'b1;
        continue;
      end
      if (!reset) txPrev = bus.tx;
    end
  end

  initial begin : stimulus
    reset        = 1'b1;
    bus.dvsr     = DVSR_W'(2);
    bus.tx_start = 1'b0;
    bus.din      = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetTx", int'(bus.tx), 1);
    checkOutput("resetDone", int'(bus.tx_done_tick), 0);
    checkOutput("resetTick", int'(bus.tick), 0);
    reset = 1'b0;

    checkTickPeriod(2);
    checkTickPeriod(0);
    bus.dvsr = DVSR_W'(2);
    repeat (5) @(negedge clk);

    gapExp = -1;
    applyStimulus(8'hAA, 20, 1'b1);
    waitDone(2000);

    for (int f = 0; f < 4; f++) begin
      repeat (20) @(negedge clk);
      gapExp = 22;
      applyStimulus(8'($urandom), 20, 1'b1);
      waitDone(2000);
    end

    for (int f = 0; f < 6; f++) begin
      repeat (10) @(negedge clk);
      bus.dvsr = DVSR_W'($urandom_range(0, 3));
      repeat (5) @(negedge clk);
      gapExp = -1;
      applyStimulus(8'($urandom), int'($urandom_range(1, 30)), 1'b1);
      waitDone(2000);
    end

    repeat (10) @(negedge clk);
    bus.dvsr = DVSR_W'(1);
    repeat (5) @(negedge clk);
    gapExp       = -1;
    bus.din      = 8'($urandom);
    bus.tx_start = 1'b1;
    sb.push_back(frameOf(bus.din));
    expDone++;
    for (int f = 0; f < 4; f++) begin
      repeat (60) @(negedge clk);
      bus.din = 8'($urandom);
      waitDone(2000);
      if (f < 3) begin
        bus.din = 8'($urandom);
        sb.push_back(frameOf(bus.din));
        expDone++;
        gapExp = 3;
      end else begin
        bus.tx_start = 1'b0;
      end
    end

    repeat (30) @(negedge clk);
    bus.dvsr = DVSR_W'(2);
    repeat (5) @(negedge clk);
    gapExp = -1;
    applyStimulus(8'($urandom), 20, 1'b0);
    repeat (130) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midResetTx", int'(bus.tx), 1);
    checkOutput("midResetDone", int'(bus.tx_done_tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    checkOutput("noDoneAfterReset", doneCount, expDone);
    applyStimulus(8'($urandom), 20, 1'b1);
    waitDone(2000);

    repeat (50) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 0);
    checkOutput("doneCount", doneCount, expDone);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
